voice_cmd_rx: RTL and testbench



---
 rtl/voice_pkg.sv | 55 +++++
 rtl/uart_rx_byte.sv | 107 ++++++++++
 rtl/voice_cmd_rx.sv | 109 ++++++++++
 tb/tb_voice_cmd_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/voice_pkg.sv
// Shared codes and types for the voice command path.
// The billing block imports the same VOICE_* constants.
package voice_pkg;

    localparam logic [2:0] VOICE_IDLE  = 3'b111;
    localparam logic [2:0] VOICE_ITEM1 = 3'b001;
    localparam logic [2:0] VOICE_ITEM2 = 3'b010;
    localparam logic [2:0] VOICE_ITEM3 = 3'b100;
    localparam logic [2:0] VOICE_ITEM4 = 3'b011;
    localparam logic [2:0] VOICE_CLEAR = 3'b000;

    localparam logic [7:0] FRAME_HDR = 8'hAA;
    localparam logic [7:0] FRAME_TRL = 8'h55;

    localparam logic [7:0] CMD_CLEAR = 8'h00;
    localparam logic [7:0] CMD_ITEM1 = 8'h01;
    localparam logic [7:0] CMD_ITEM2 = 8'h02;
    localparam logic [7:0] CMD_ITEM3 = 8'h03;
    localparam logic [7:0] CMD_ITEM4 = 8'h04;

    typedef enum logic [1:0] {
        HUNT,
        HDR,
        CMD
    } parse_state_t;

    typedef enum logic [2:0] {
        RX_WAIT_IDLE,
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       known;
        logic [2:0] code;
    } cmd_decode_t;

    function automatic cmd_decode_t decode_cmd(input logic [7:0] cmd_byte);
        cmd_decode_t d;
        d.known = 1'b1;
        d.code  = VOICE_IDLE;
        case (cmd_byte)
            CMD_CLEAR: d.code = VOICE_CLEAR;
            CMD_ITEM1: d.code = VOICE_ITEM1;
            CMD_ITEM2: d.code = VOICE_ITEM2;
            CMD_ITEM3: d.code = VOICE_ITEM3;
            CMD_ITEM4: d.code = VOICE_ITEM4;
            default:   d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, start-glitch
// rejection and stop-bit checking.
module uart_rx_byte
    import voice_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clock,
    input  logic       clr_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_stb,
    output logic       stop_err
);

    localparam int BIT_CNT  = CLK_HZ / BAUD;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CW       = $clog2(BIT_CNT);

    rx_state_t      state;
    rx_state_t      state_next;
    logic [1:0]     sync;
    logic           rx_s;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           half_tick;
    logic           full_tick;
    logic           sample_stop;

    assign rx_s      = sync[1];
    assign half_tick = (cnt == CW'(HALF_CNT - 1));
    assign full_tick = (cnt == CW'(BIT_CNT - 1));

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state <= RX_WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // After reset or a bad stop bit the line must be seen high before a
    // falling edge can start a byte, so a low line is never mistaken for one.
    always_comb begin
        state_next  = state;
        sample_stop = 1'b0;
        unique case (state)
            RX_WAIT_IDLE: if (rx_s) state_next = RX_IDLE;
            RX_IDLE:      if (!rx_s) state_next = RX_START;
            RX_START: begin
                if (half_tick) state_next = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (full_tick && bit_idx == 3'd7) state_next = RX_STOP;
            end
            RX_STOP: begin
                if (full_tick) begin
                    sample_stop = 1'b1;
                    state_next  = rx_s ? RX_IDLE : RX_WAIT_IDLE;
                end
            end
            default: state_next = RX_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_data <= '0;
            byte_stb  <= 1'b0;
            stop_err  <= 1'b0;
        end else begin
            if (state == RX_IDLE || state == RX_WAIT_IDLE ||
                state_next != state || full_tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (state == RX_START) begin
                bit_idx <= '0;
            end else if (state == RX_DATA && full_tick) begin
                bit_idx <= bit_idx + 3'd1;
                shift   <= {rx_s, shift[7:1]};
            end

            byte_stb <= sample_stop && rx_s;
            stop_err <= sample_stop && !rx_s;
            if (sample_stop && rx_s) begin
                byte_data <= shift;
            end
        end
    end

endmodule

// File: rtl/voice_cmd_rx.sv
// Voice command front end: parses AA/cmd/55 frames from the UART receiver
// and drives a held 3-bit code, returning to the idle/arm code in between.
module voice_cmd_rx
    import voice_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clock,
    input  logic       clr_n,
    input  logic       rx,
    output logic [2:0] voice,
    output logic       cmd_valid,
    output logic       frame_err
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic [7:0]   byte_data;
    logic         byte_stb;
    logic         stop_err;
    parse_state_t state;
    parse_state_t state_next;
    logic [7:0]   cmd_byte;
    cmd_decode_t  dec;
    logic         emit;
    logic         bad;
    logic [HW-1:0] hold_cnt;

    uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clock     (clock),
        .clr_n     (clr_n),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_stb  (byte_stb),
        .stop_err  (stop_err)
    );

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // A non-trailer byte in CMD that is itself a header restarts the frame.
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        bad        = 1'b0;
        dec        = decode_cmd(cmd_byte);
        if (stop_err) begin
            state_next = HUNT;
            bad        = 1'b1;
        end else if (byte_stb) begin
            unique case (state)
                HUNT: if (byte_data == FRAME_HDR) state_next = HDR;
                HDR:  state_next = CMD;
                CMD: begin
                    if (byte_data == FRAME_TRL) begin
                        emit       = dec.known;
                        bad        = !dec.known;
                        state_next = HUNT;
                    end else begin
                        bad        = 1'b1;
                        state_next = (byte_data == FRAME_HDR) ? HDR : HUNT;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    assign frame_err = bad;

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            cmd_byte <= '0;
        end else if (byte_stb && state == HDR) begin
            cmd_byte <= byte_data;
        end
    end

    // Code is driven for exactly HOLD_CYCLES cycles, then back to idle.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            voice     <= VOICE_IDLE;
            cmd_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            cmd_valid <= emit;
            if (emit) begin
                voice    <= dec.code;
                hold_cnt <= HW'(HOLD_CYCLES);
            end else if (hold_cnt == HW'(1)) begin
                voice    <= VOICE_IDLE;
                hold_cnt <= '0;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_voice_cmd_rx.sv
// Scoreboard bench for voice_cmd_rx: stimulus pushes expected events, a
// negedge monitor pops them and checks the held code cycle by cycle.
module tb_voice_cmd_rx;
    import voice_pkg::*;

    localparam int CLK_HZ = 3_200_000;
    localparam int BAUD   = 100_000;
    localparam int HOLD   = 16;
    localparam int BIT    = CLK_HZ / BAUD;

    logic       clock = 1'b0;
    logic       clr_n = 1'b0;
    logic       rx    = 1'b1;
    logic [2:0] voice;
    logic       cmd_valid;
    logic       frame_err;

    typedef struct {
        bit         is_err;
        logic [2:0] code;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_codes  = 0;
    int         n_errs   = 0;
    int         mon_left = 0;
    logic [2:0] mon_code = VOICE_IDLE;

    always #5 clock = ~clock;

    voice_cmd_rx #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock     (clock),
        .clr_n     (clr_n),
        .rx        (rx),
        .voice     (voice),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic expect_code(input logic [2:0] code);
        exp_t e;
        e.is_err = 1'b0;
        e.code   = code;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.code   = VOICE_IDLE;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (BIT) @(negedge clock);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clock);
        rx = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] b2);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
    endtask

    // Monitor: every cycle voice must be either the expected held code or idle.
    always @(negedge clock) begin
        exp_t e;
        if (!clr_n) begin
            mon_left = 0;
            check_output("voice_in_reset", 32'(voice), 32'(VOICE_IDLE));
            check_output("valid_in_reset", 32'(cmd_valid), 32'd0);
            check_output("err_in_reset", 32'(frame_err), 32'd0);
        end else begin
            check_output("valid_err_overlap", 32'(cmd_valid & frame_err), 32'd0);
            if (cmd_valid) begin
                n_codes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_code: got voice %b, required no event", voice);
                end else begin
                    e = exp_q.pop_front();
                    check_output("event_kind_code", 32'(e.is_err), 32'd0);
                    mon_code = e.code;
                    mon_left = HOLD;
                end
            end
            if (frame_err) begin
                n_errs++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_err: got frame_err 1, required no event");
                end else begin
                    e = exp_q.pop_front();
                    check_output("event_kind_err", 32'(e.is_err), 32'd1);
                end
            end
            if (mon_left > 0) begin
                check_output("voice_hold", 32'(voice), 32'(mon_code));
                mon_left--;
            end else begin
                check_output("voice_idle", 32'(voice), 32'(VOICE_IDLE));
            end
        end
    end

    initial begin
        clr_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clock);
        check_output("reset_voice", 32'(voice), 32'(VOICE_IDLE));
        check_output("reset_valid", 32'(cmd_valid), 32'd0);
        check_output("reset_err", 32'(frame_err), 32'd0);
        clr_n = 1'b1;
        repeat (2 * BIT) @(negedge clock);

        $display("[TB] nominal frame AA 01 55");
        expect_code(VOICE_ITEM1);
        apply_stimulus(8'hAA, 8'h01, 8'h55);
        repeat (2 * BIT) @(negedge clock);

        $display("[TB] all codes back to back");
        expect_code(VOICE_CLEAR);
        expect_code(VOICE_ITEM2);
        expect_code(VOICE_ITEM3);
        expect_code(VOICE_ITEM4);
        apply_stimulus(8'hAA, 8'h00, 8'h55);
        apply_stimulus(8'hAA, 8'h02, 8'h55);
        apply_stimulus(8'hAA, 8'h03, 8'h55);
        apply_stimulus(8'hAA, 8'h04, 8'h55);
        repeat (2 * BIT) @(negedge clock);

        $display("[TB] bad trailer and resync AA 02 AA 03 55");
        expect_err();
        expect_code(VOICE_ITEM3);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h02, 1'b1);
        apply_stimulus(8'hAA, 8'h03, 8'h55);
        repeat (2 * BIT) @(negedge clock);

        $display("[TB] unknown command AA 07 55");
        expect_err();
        apply_stimulus(8'hAA, 8'h07, 8'h55);
        repeat (2 * BIT) @(negedge clock);

        $display("[TB] stop-bit error then 01 55");
        expect_err();
        send_byte(8'hAA, 1'b0);
        repeat (2 * BIT) @(negedge clock);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (2 * BIT) @(negedge clock);

        $display("[TB] short low glitch on idle line");
        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clock);

        $display("[TB] reset during command byte, then AA 04 55");
        fork
            apply_stimulus(8'hAA, 8'h01, 8'h55);
            begin
                repeat (14 * BIT) @(negedge clock);
                clr_n = 1'b0;
            end
        join
        repeat (BIT) @(negedge clock);
        clr_n = 1'b1;
        repeat (2 * BIT) @(negedge clock);
        expect_code(VOICE_ITEM4);
        apply_stimulus(8'hAA, 8'h04, 8'h55);
        repeat (3 * BIT) @(negedge clock);

        check_output("pending_events", 32'(exp_q.size()), 32'd0);
        check_output("code_pulse_count", 32'(n_codes), 32'd7);
        check_output("err_pulse_count", 32'(n_errs), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
